// File: rtl/mips_pc_branch_controller.sv
// PC sequencer: resolves branch type + ALU zero, redirects fetch on a taken branch,
// then holds flush high for a fixed number of unstalled cycles to squash wrong-path fetches.
module mips_pc_branch_controller #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  FLUSH_CYCLES = 2,
  parameter int                  CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_valid,
  input  logic [1:0]           branch,
  input  logic                 zero,
  input  logic [PC_WIDTH-1:0]  branch_target,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 flush,
  output logic                 is_taken,
  output logic                 taken_pulse,
  output logic [CNT_WIDTH-1:0] taken_count
);

  localparam int FCNT_W = $clog2(FLUSH_CYCLES) + 1;

  typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [FCNT_W-1:0]    r_fcnt, w_fcnt_nxt;
  logic [PC_WIDTH-1:0]  r_pc, w_pc_nxt;
  logic                 r_pulse, w_pulse_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                 w_is_taken;
  logic [PC_WIDTH-1:0]  w_target;
  logic [PC_WIDTH-1:0]  w_pc_inc;

  // The redirect counter sticks at all-ones rather than wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    w_is_taken = 1'b0;
    if (branch_valid) begin
      unique case (branch)
        2'b01:   w_is_taken = zero;
        2'b10:   w_is_taken = ~zero;
        2'b11:   w_is_taken = 1'b1;
        default: w_is_taken = 1'b0;
      endcase
    end
  end

  assign w_target = branch_target & ~PC_WIDTH'(3);
  assign w_pc_inc = r_pc + PC_WIDTH'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
      r_fcnt  <= '0;
      r_pc    <= RESET_PC;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_pc    <= w_pc_nxt;
      r_pulse <= w_pulse_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Branch decisions presented while in FLUSH belong to wrong-path instructions.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_pc_nxt    = r_pc;
    w_pulse_nxt = 1'b0;
    w_cnt_nxt   = r_cnt;
    if (!stall) begin
      unique case (r_state)
        S_RUN: begin
          if (w_is_taken) begin
            w_pc_nxt    = w_target;
            w_state_nxt = S_FLUSH;
            w_fcnt_nxt  = FCNT_W'(FLUSH_CYCLES - 1);
            w_pulse_nxt = 1'b1;
            w_cnt_nxt   = sat_inc(r_cnt);
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
        S_FLUSH: begin
          w_pc_nxt = w_pc_inc;
          if (r_fcnt == '0) w_state_nxt = S_RUN;
          else              w_fcnt_nxt  = r_fcnt - FCNT_W'(1);
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  always_comb begin
    pc          = r_pc;
    flush       = (r_state == S_FLUSH);
    is_taken    = w_is_taken;
    taken_pulse = r_pulse;
    taken_count = r_cnt;
  end

endmodule

// File: tb/tb_mips_pc_branch_controller.sv
// Bench for mips_pc_branch_controller: two parameterisations share one stimulus stream and
// are checked every cycle against a flush-budget model, plus hand-computed anchor values.
module tb_mips_pc_branch_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic [1:0]  branch = 2'b00;
  logic        zero = 1'b0;
  logic [31:0] branch_target = '0;

  logic [31:0] pc_a, pc_b;
  logic        flush_a, flush_b, tk_a, tk_b, pulse_a, pulse_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_pc_branch_controller #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000),
                              .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .branch_valid(branch_valid),
    .branch(branch), .zero(zero), .branch_target(branch_target),
    .pc(pc_a), .flush(flush_a), .is_taken(tk_a), .taken_pulse(pulse_a), .taken_count(cnt_a));

  mips_pc_branch_controller #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC),
                              .FLUSH_CYCLES(1), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .branch_valid(branch_valid),
    .branch(branch), .zero(zero), .branch_target(branch_target),
    .pc(pc_b), .flush(flush_b), .is_taken(tk_b), .taken_pulse(pulse_b), .taken_count(cnt_b));

  // Model: a flush budget of remaining unstalled squash cycles; flush is "budget > 0".
  localparam logic [31:0] RPC [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
  localparam int          FC  [2] = '{2, 1};
  localparam int          CMAX[2] = '{65535, 3};

  logic [31:0] m_pc   [2];
  int          m_left [2];
  logic        m_pulse[2];
  int          m_cnt  [2];

  function automatic logic ref_taken(input logic v, input logic [1:0] b, input logic z);
    if (!v) return 1'b0;
    case (b)
      2'b01:   return z;
      2'b10:   return !z;
      2'b11:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pc[k] = RPC[k]; m_left[k] = 0; m_pulse[k] = 1'b0; m_cnt[k] = 0;
      end else if (stall) begin
        m_pulse[k] = 1'b0;
      end else if (m_left[k] > 0) begin
        m_pc[k] = m_pc[k] + 32'd4; m_left[k] = m_left[k] - 1; m_pulse[k] = 1'b0;
      end else if (ref_taken(branch_valid, branch, zero)) begin
        m_pc[k] = {branch_target[31:2], 2'b00};
        m_left[k] = FC[k]; m_pulse[k] = 1'b1;
        if (m_cnt[k] < CMAX[k]) m_cnt[k] = m_cnt[k] + 1;
      end else begin
        m_pc[k] = m_pc[k] + 32'd4; m_pulse[k] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic t;
    t = ref_taken(branch_valid, branch, zero);
    chk("a.pc", pc_a, m_pc[0]);
    chk("a.flush", {31'd0, flush_a}, {31'd0, m_left[0] > 0});
    chk("a.is_taken", {31'd0, tk_a}, {31'd0, t});
    chk("a.pulse", {31'd0, pulse_a}, {31'd0, m_pulse[0]});
    chk("a.count", {16'd0, cnt_a}, 32'(m_cnt[0]));
    chk("b.pc", pc_b, m_pc[1]);
    chk("b.flush", {31'd0, flush_b}, {31'd0, m_left[1] > 0});
    chk("b.is_taken", {31'd0, tk_b}, {31'd0, t});
    chk("b.pulse", {31'd0, pulse_b}, {31'd0, m_pulse[1]});
    chk("b.count", {30'd0, cnt_b}, 32'(m_cnt[1]));
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] b, input logic z,
                       input logic [31:0] t, input logic s);
    branch_valid = v; branch = b; zero = z; branch_target = t; stall = s;
    #1;
  endtask

  // Anchor both the DUT and the model to a hand-computed value.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                     input logic [31:0] exp);
    chk({name, ".dut"}, act, exp);
    chk({name, ".model"}, mdl, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    // Sequential fetch and wrap on the high reset vector
    lit("rst.pc_a", pc_a, m_pc[0], 32'h0);
    lit("rst.pc_b", pc_b, m_pc[1], 32'hFFFF_FFFC);
    lit("rst.cnt_a", {16'd0, cnt_a}, 32'(m_cnt[0]), 32'd0);
    chk("rst.flush_a", {31'd0, flush_a}, 32'd0);
    tick();
    lit("seq.pc_a4", pc_a, m_pc[0], 32'h4);
    lit("wrap.pc_b", pc_b, m_pc[1], 32'h0);
    tick();
    lit("seq.pc_a8", pc_a, m_pc[0], 32'h8);

    // Taken beq at pc 0x8
    drive(1'b1, 2'b01, 1'b1, 32'h40, 1'b0);
    chk("beq.is_taken", {31'd0, tk_a}, 32'd1);
    tick();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
    lit("beq.pc", pc_a, m_pc[0], 32'h40);
    chk("beq.pulse", {31'd0, pulse_a}, 32'd1);
    chk("beq.flush0", {31'd0, flush_a}, 32'd1);
    lit("beq.cnt", {16'd0, cnt_a}, 32'(m_cnt[0]), 32'd1);
    tick();
    lit("beq.pc44", pc_a, m_pc[0], 32'h44);
    chk("beq.flush1", {31'd0, flush_a}, 32'd1);
    chk("beq.pulse_off", {31'd0, pulse_a}, 32'd0);
    tick();
    lit("beq.pc48", pc_a, m_pc[0], 32'h48);
    chk("beq.flush_off", {31'd0, flush_a}, 32'd0);

    // Not-taken bne and branch=00
    drive(1'b1, 2'b10, 1'b1, 32'h80, 1'b0);
    chk("bne.not_taken", {31'd0, tk_a}, 32'd0);
    tick();
    lit("bne.pc", pc_a, m_pc[0], 32'h4C);
    drive(1'b1, 2'b00, 1'b1, 32'h80, 1'b0);
    chk("none.z1", {31'd0, tk_a}, 32'd0);
    tick();
    drive(1'b1, 2'b00, 1'b0, 32'h80, 1'b0);
    chk("none.z0", {31'd0, tk_a}, 32'd0);
    tick();
    lit("none.pc", pc_a, m_pc[0], 32'h54);
    lit("none.cnt", {16'd0, cnt_a}, 32'(m_cnt[0]), 32'd1);

    // Jump with unaligned target, stall inside FLUSH, jump ignored during FLUSH
    drive(1'b1, 2'b11, 1'b0, 32'h103, 1'b0);
    tick();
    lit("jmp.pc", pc_a, m_pc[0], 32'h100);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b1);
    repeat (3) tick();
    lit("stall.pc", pc_a, m_pc[0], 32'h100);
    chk("stall.flush", {31'd0, flush_a}, 32'd1);
    chk("stall.pulse", {31'd0, pulse_a}, 32'd0);
    drive(1'b1, 2'b11, 1'b0, 32'h200, 1'b0);
    tick();
    lit("fl.pc104", pc_a, m_pc[0], 32'h104);
    chk("fl.flush", {31'd0, flush_a}, 32'd1);
    tick();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
    lit("fl.pc108", pc_a, m_pc[0], 32'h108);
    chk("fl.flush_off", {31'd0, flush_a}, 32'd0);
    lit("fl.cnt", {16'd0, cnt_a}, 32'(m_cnt[0]), 32'd2);

    // Asynchronous reset in the middle of a flush window
    drive(1'b1, 2'b11, 1'b0, 32'h300, 1'b0);
    tick();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
    chk("ar.pre_flush", {31'd0, flush_a}, 32'd1);
    reset = 1'b1;
    #1;
    lit("ar.pc_a", pc_a, m_pc[0], 32'h0);
    lit("ar.pc_b", pc_b, m_pc[1], 32'hFFFF_FFFC);
    chk("ar.flush_a", {31'd0, flush_a}, 32'd0);
    chk("ar.cnt_a", {16'd0, cnt_a}, 32'd0);
    #1 reset = 1'b0;
    tick();

    // Five taken jumps: wide counter reaches 5, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b11, 1'b0, 32'h1000 + 32'(i) * 32'h40, 1'b0);
      tick();
      drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
      repeat (3) tick();
    end
    lit("sat.cnt_a", {16'd0, cnt_a}, 32'(m_cnt[0]), 32'd5);
    lit("sat.cnt_b", {30'd0, cnt_b}, 32'(m_cnt[1]), 32'd3);

    // Randomised traffic with occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
